game_flow_controller: RTL and testbench
=======================================

Name: game_flow_controller

Overview:
Top-level game sequencer for the road-fighter datapath. It owns the game state (idle, get-ready, playing, crash, game over), the lives and score counters, and the gating of the frame ticks (upsig, upsig_fast) and obstacle drop requests that drive the player, obstacle manager and background. It samples the collision-manager output once per frame and clears the obstacle field between rounds.

Parameters:
LIVES_INIT, 3, lives loaded at game start; legal range 1..3.
READY_FRAMES, 60, upsig ticks spent in READY; legal range 1..255.
CRASH_FRAMES, 120, upsig ticks spent in CRASH; legal range 1..255.
SCORE_W, 16, score counter width.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
start  in  1  start button level, already synchronised to clk
upsig  in  1  frame tick, 1-cycle pulse
upsig_fast  in  1  fast animation tick, 1-cycle pulse
colision  in  1  level from the collision manager
drop_req  in  1  obstacle drop request from the spawn source
run_upsig  out  1  gated upsig to player and obstacle manager
run_upsig_fast  out  1  gated upsig_fast to background and car graphics
drop  out  1  gated drop request to the obstacle manager
obs_clear  out  1  1-cycle pulse that empties all obstacle slots
player_visible  out  1  player car on-enable for the graphic controller
state  out  3  IDLE=0, READY=1, PLAY=2, CRASH=3, OVER=4
lives  out  2  remaining lives
score  out  SCORE_W  frames survived
game_over  out  1  high while in OVER

Behaviour:
- Reset, asynchronous, to these values: state=IDLE, lives=LIVES_INIT, score=0, obs_clear=0, player_visible=1, game_over=0, internal counter=0, start_prev=0.
- start_edge = start & ~start_prev. start_prev is registered every cycle.
- Gating is combinational from the registered state:
  - run_upsig = upsig & (state==PLAY)
  - run_upsig_fast = upsig_fast & (state==PLAY)
  - drop = drop_req & (state==PLAY)
- game_over = (state==OVER), registered with state.
- Frame counter (8 bit): on entry to READY or CRASH it loads N-1. On each upsig in that state: if cnt==0 the state exits, else cnt decrements. The state therefore lasts exactly N upsig ticks.
- IDLE:
  - lives is held at LIVES_INIT and score at 0.
  - start_edge -> READY; obs_clear pulses on the next cycle.
- READY: player_visible=1. Counter expiry -> PLAY.
- PLAY:
  - On upsig with colision=0: score increments, saturating at all-ones.
  - On upsig with colision=1: score is unchanged and lives decrements.
    - If lives was 1, go to OVER.
    - Otherwise go to CRASH and load CRASH_FRAMES-1.
  - colision outside upsig cycles is ignored.
  - The upsig of the crash cycle is still forwarded on run_upsig, because state is still PLAY in that cycle.
- CRASH:
  - player_visible = cnt[3], giving a blink every 8 frames. It returns to 1 on exit.
  - Counter expiry -> READY with READY_FRAMES-1 loaded; obs_clear pulses one cycle after expiry.
- OVER:
  - Outputs stay gated; lives=0 and score is frozen.
  - start_edge -> READY with lives=LIVES_INIT and score=0; obs_clear pulses.
  - Holding start high with no new edge keeps the block in OVER.
- start_edge in READY, PLAY or CRASH is ignored.
- obs_clear is registered and never lasts more than 1 cycle. A transition with obs_clear and upsig in the same cycle behaves the same as a transition without upsig.
- Reset asserted mid-operation in any state returns all registers to their reset values immediately.
- No combinational path from colision or start to any output; only upsig, upsig_fast and drop_req pass combinationally.

Test Plan:
1. Assert and release reset -> state=0, lives=3, score=0, game_over=0, player_visible=1. Pulses on upsig, upsig_fast and drop_req -> run_upsig, run_upsig_fast and drop all stay 0.
2. READY_FRAMES=4; raise start -> obs_clear high exactly 1 cycle, state=1. After the 4th upsig -> state=2, and the 5th upsig appears on run_upsig.
3. In PLAY, send 10 upsig with colision=0 -> score=10 and drop mirrors drop_req. Drive colision high only between ticks -> no state change, lives=3.
4. CRASH_FRAMES=4; colision high on an upsig -> state=3 and lives=2 next cycle, score unchanged.
   - run_upsig stays 0 while player_visible follows cnt[3].
   - After 4 upsig -> obs_clear pulse and state=1.
5. Third crash -> state=4, lives=0, game_over=1.
   - Start held high from before the crash -> block stays in OVER.
   - Release and re-press start -> state=1, lives=3, score=0, obs_clear pulse.
6. SCORE_W=4: run 20 clean frames -> score saturates at 15. Assert reset in the middle of CRASH -> state=0 immediately, lives=3.

Source files
------------

// File: rtl/game_flow_controller.sv
// game_flow_controller
// Top-level game sequencer for the road-fighter datapath. It owns the game
// state, the lives and score counters, and it gates the frame ticks and the
// obstacle drop requests. Between rounds it issues a one-cycle obs_clear
// pulse that empties the obstacle field.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   start               start button level (already synchronised to clk)
//   upsig, upsig_fast   frame tick / fast animation tick (1-cycle pulses)
//   colision            collision-manager level, sampled on upsig in PLAY
//   drop_req            obstacle drop request from the spawn source
//   run_upsig           upsig gated by PLAY
//   run_upsig_fast      upsig_fast gated by PLAY
//   drop                drop_req gated by PLAY
//   obs_clear           registered 1-cycle pulse on every entry to READY
//   player_visible      player car enable (blinks during CRASH)
//   state               IDLE=0, READY=1, PLAY=2, CRASH=3, OVER=4
//   lives, score        remaining lives, frames survived (saturating)
//   game_over           high while in OVER
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | power-up, lives=LIVES_INIT, score=0, waits for a start edge
// READY | get-ready pause, READY_FRAMES upsig ticks, car shown
// PLAY  | ticks forwarded, score counts clean frames, collision checked
// CRASH | crash pause, CRASH_FRAMES upsig ticks, car blinks
// OVER  | no lives left, score frozen, waits for a new start edge

module game_flow_controller #(
    parameter int LIVES_INIT   = 3,
    parameter int READY_FRAMES = 60,
    parameter int CRASH_FRAMES = 120,
    parameter int SCORE_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               upsig,
    input  logic               upsig_fast,
    input  logic               colision,
    input  logic               drop_req,
    output logic               run_upsig,
    output logic               run_upsig_fast,
    output logic               drop,
    output logic               obs_clear,
    output logic               player_visible,
    output logic [2:0]         state,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_PLAY  = 3'd2,
        S_CRASH = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [7:0]         READY_LOAD = 8'(READY_FRAMES - 1);
    localparam logic [7:0]         CRASH_LOAD = 8'(CRASH_FRAMES - 1);
    localparam logic [1:0]         LIVES_LOAD = 2'(LIVES_INIT);
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    state_t             r_state;
    state_t             w_state_next;
    logic [7:0]         r_cnt;
    logic [1:0]         r_lives;
    logic [SCORE_W-1:0] r_score;
    logic               r_obs_clear;
    logic               r_game_over;
    logic               r_start_prev;
    logic               w_start_edge;
    logic               w_cnt_zero;
    logic               w_timed_state;

    assign w_start_edge  = start & ~r_start_prev;
    assign w_cnt_zero    = (r_cnt == 8'd0);
    assign w_timed_state = (r_state == S_READY) || (r_state == S_CRASH);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) w_state_next = S_READY;
            end
            S_READY: begin
                if (upsig && w_cnt_zero) w_state_next = S_PLAY;
            end
            S_PLAY: begin
                if (upsig && colision) begin
                    // The last life is lost here: skip the crash pause.
                    w_state_next = (r_lives == 2'd1) ? S_OVER : S_CRASH;
                end
            end
            S_CRASH: begin
                if (upsig && w_cnt_zero) w_state_next = S_READY;
            end
            S_OVER: begin
                if (w_start_edge) w_state_next = S_READY;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Frame counter, lives, score and registered flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= 8'd0;
            r_lives      <= LIVES_LOAD;
            r_score      <= '0;
            r_obs_clear  <= 1'b0;
            r_game_over  <= 1'b0;
            r_start_prev <= 1'b0;
        end else begin
            r_start_prev <= start;
            // Every entry into READY starts a fresh round with an empty field.
            r_obs_clear  <= (w_state_next == S_READY) && (r_state != S_READY);
            r_game_over  <= (w_state_next == S_OVER);

            // Load N-1 on entry so the timed state lasts exactly N ticks.
            if (w_state_next != r_state) begin
                if (w_state_next == S_READY) begin
                    r_cnt <= READY_LOAD;
                end else if (w_state_next == S_CRASH) begin
                    r_cnt <= CRASH_LOAD;
                end
            end else if (upsig && w_timed_state && !w_cnt_zero) begin
                r_cnt <= r_cnt - 8'd1;
            end

            case (r_state)
                S_IDLE: begin
                    r_lives <= LIVES_LOAD;
                    r_score <= '0;
                end
                S_PLAY: begin
                    if (upsig) begin
                        if (colision) begin
                            r_lives <= r_lives - 2'd1;
                        end else if (r_score != SCORE_MAX) begin
                            r_score <= r_score + SCORE_ONE;
                        end
                    end
                end
                S_OVER: begin
                    if (w_start_edge) begin
                        r_lives <= LIVES_LOAD;
                        r_score <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: only the tick/drop inputs pass combinationally, all else is
    // derived from registers.
    always_comb begin
        run_upsig      = upsig      & (r_state == S_PLAY);
        run_upsig_fast = upsig_fast & (r_state == S_PLAY);
        drop           = drop_req   & (r_state == S_PLAY);
        // cnt[3] toggles every 8 frames while the crash counter runs down.
        player_visible = (r_state == S_CRASH) ? r_cnt[3] : 1'b1;
        obs_clear      = r_obs_clear;
        game_over      = r_game_over;
        state          = r_state;
        lives          = r_lives;
        score          = r_score;
    end

endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench for game_flow_controller. The stimulus process pushes the
// expected output snapshot for every change it provokes; the monitor pops
// one entry each time the sampled output vector differs from the previous
// sample. Snapshot layout: {state, lives, score, game_over, obs_clear,
// player_visible, run_upsig, run_upsig_fast, drop}.

module tb_game_flow_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       upsig = 1'b0;
    logic       upsig_fast = 1'b0;
    logic       colision = 1'b0;
    logic       drop_req = 1'b0;
    logic       run_upsig;
    logic       run_upsig_fast;
    logic       drop;
    logic       obs_clear;
    logic       player_visible;
    logic [2:0] state;
    logic [1:0] lives;
    logic [3:0] score;
    logic       game_over;

    game_flow_controller #(
        .LIVES_INIT  (3),
        .READY_FRAMES(4),
        .CRASH_FRAMES(4),
        .SCORE_W     (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .upsig         (upsig),
        .upsig_fast    (upsig_fast),
        .colision      (colision),
        .drop_req      (drop_req),
        .run_upsig     (run_upsig),
        .run_upsig_fast(run_upsig_fast),
        .drop          (drop),
        .obs_clear     (obs_clear),
        .player_visible(player_visible),
        .state         (state),
        .lives         (lives),
        .score         (score),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    string       q_name[$];
    logic [14:0] q_val[$];

    task automatic push_exp(input string nm, input int st, input int lv, input int sc,
                            input bit go, input bit oc, input bit pv,
                            input bit ru, input bit rf, input bit dr);
        q_name.push_back(nm);
        q_val.push_back({3'(st), 2'(lv), 4'(sc), go, oc, pv, ru, rf, dr});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        upsig = 1'b1;
        step(1);
        upsig = 1'b0;
        step(1);
    endtask

    // One clean PLAY frame: forwarded tick, then the score update.
    task automatic play_tick(input int lv, input int s);
        push_exp("play_fwd", 2, lv, s, 0, 0, 1, 1, 0, 0);
        push_exp("play_score", 2, lv, (s == 15) ? 15 : s + 1, 0, 0, 1, 0, 0, 0);
        tick();
    endtask

    task automatic ready_to_play(input int lv, input int s);
        push_exp("ready_to_play", 2, lv, s, 0, 0, 1, 0, 0, 0);
        repeat (4) tick();
    endtask

    task automatic crash_to_ready(input int lv, input int s);
        push_exp("crash_exit_clr", 1, lv, s, 0, 1, 1, 0, 0, 0);
        push_exp("crash_exit_ready", 1, lv, s, 0, 0, 1, 0, 0, 0);
        repeat (4) tick();
    endtask

    task automatic crash_tick(input int lv, input int s, input int st_after);
        push_exp("crash_fwd", 2, lv, s, 0, 0, 1, 1, 0, 0);
        if (st_after == 4) push_exp("enter_over", 4, 0, s, 1, 0, 1, 0, 0, 0);
        else               push_exp("enter_crash", 3, lv - 1, s, 0, 0, 0, 0, 0, 0);
        colision = 1'b1;
        tick();
        colision = 1'b0;
    endtask

    // Monitor
    initial begin : monitor
        logic [14:0] prev;
        logic [14:0] cur;
        logic [14:0] ev;
        string       nm;
        prev = 'x;
        forever begin
            @(negedge clk);
            cur = {state, lives, score, game_over, obs_clear, player_visible,
                   run_upsig, run_upsig_fast, drop};
            if (cur !== prev) begin
                n_tests++;
                if (q_val.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event @%0t got=%b required=no_change", $time, cur);
                end else begin
                    nm = q_name.pop_front();
                    ev = q_val.pop_front();
                    if (cur !== ev) begin
                        n_fail++;
                        $display("FAIL %s @%0t got=%b required=%b", nm, $time, cur, ev);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // 1: reset values, gating in IDLE
        push_exp("reset", 0, 3, 0, 0, 0, 1, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step(2);
        upsig = 1'b1; upsig_fast = 1'b1; drop_req = 1'b1;
        step(1);
        upsig = 1'b0; upsig_fast = 1'b0; drop_req = 1'b0;
        step(2);

        // 2: start -> READY with one-cycle obs_clear, 4 ticks -> PLAY
        push_exp("start_clr", 1, 3, 0, 0, 1, 1, 0, 0, 0);
        push_exp("start_clr_end", 1, 3, 0, 0, 0, 1, 0, 0, 0);
        start = 1'b1;
        step(3);
        start = 1'b0;
        ready_to_play(3, 0);

        // 3: ten clean frames, drop mirroring, colision between ticks
        for (int s = 0; s < 10; s++) play_tick(3, s);
        for (int k = 0; k < 2; k++) begin
            push_exp("drop_on", 2, 3, 10, 0, 0, 1, 0, 0, 1);
            push_exp("drop_off", 2, 3, 10, 0, 0, 1, 0, 0, 0);
            drop_req = 1'b1;
            step(1);
            drop_req = 1'b0;
            step(1);
        end
        push_exp("fast_on", 2, 3, 10, 0, 0, 1, 0, 1, 0);
        push_exp("fast_off", 2, 3, 10, 0, 0, 1, 0, 0, 0);
        upsig_fast = 1'b1;
        step(1);
        upsig_fast = 1'b0;
        step(1);
        colision = 1'b1;
        step(3);
        colision = 1'b0;
        step(1);
        start = 1'b1;
        step(2);
        start = 1'b0;
        step(1);

        // 4: crash, gated ticks during CRASH, back to READY then PLAY
        crash_tick(3, 10, 3);
        drop_req = 1'b1; upsig_fast = 1'b1;
        step(1);
        drop_req = 1'b0; upsig_fast = 1'b0;
        crash_to_ready(2, 10);
        ready_to_play(2, 10);
        crash_tick(2, 10, 3);
        crash_to_ready(1, 10);
        ready_to_play(1, 10);

        // 5: last life with start held -> OVER, held start ignored, re-press
        start = 1'b1;
        step(2);
        crash_tick(1, 10, 4);
        upsig = 1'b1; upsig_fast = 1'b1; drop_req = 1'b1;
        step(1);
        upsig = 1'b0; upsig_fast = 1'b0; drop_req = 1'b0;
        step(5);
        start = 1'b0;
        step(2);
        push_exp("restart_clr", 1, 3, 0, 0, 1, 1, 0, 0, 0);
        push_exp("restart_ready", 1, 3, 0, 0, 0, 1, 0, 0, 0);
        start = 1'b1;
        step(3);
        start = 1'b0;

        // 6: score saturation at 15, async reset during CRASH
        ready_to_play(3, 0);
        for (int i = 0; i < 20; i++) play_tick(3, (i < 15) ? i : 15);
        crash_tick(3, 15, 3);
        tick();
        tick();
        push_exp("reset_mid_crash", 0, 3, 0, 0, 0, 1, 0, 0, 0);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(3);

        while (q_val.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL missing_event %s got=none required=%b", q_name.pop_front(), q_val.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
